// File: rtl/quad_encoder_pkg.sv
// Shared constants for the quadrature encoder counter: register map, CTRL/STATUS
// bit positions, decode mode encodings and the byte-lane merge used by bus writes.
package quad_encoder_pkg;

  localparam logic [2:0] ADDR_ID       = 3'd0;
  localparam logic [2:0] ADDR_POSITION = 3'd1;
  localparam logic [2:0] ADDR_STATUS   = 3'd2;
  localparam logic [2:0] ADDR_CTRL     = 3'd3;
  localparam logic [2:0] ADDR_INDEX    = 3'd4;
  localparam logic [2:0] ADDR_VELOCITY = 3'd5;
  localparam logic [2:0] ADDR_PERIOD   = 3'd6;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_ZCLR     = 1;
  localparam int unsigned CTRL_INV      = 2;
  localparam int unsigned CTRL_MODE_LSB = 4;

  localparam int unsigned ST_DIR     = 0;
  localparam int unsigned ST_INDEX   = 1;
  localparam int unsigned ST_ILLEGAL = 2;
  localparam int unsigned ST_WRAP    = 3;

  localparam logic [1:0] MODE_X1 = 2'b00;
  localparam logic [1:0] MODE_X2 = 2'b01;
  localparam logic [1:0] MODE_X4 = 2'b10;

  localparam logic [5:0] CTRL_RESET = 6'h21;
  // Bit 3 of CTRL is unimplemented and always reads 0.
  localparam logic [5:0] CTRL_WMASK = 6'h37;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/quad_encoder_counter_if.sv
// Avalon-MM slave bundle of the encoder counter (avs_ctrl).
//   master: drives writedata/byteenable/address/write/read, samples readdata/waitrequest
//   slave : the counter side
interface quad_encoder_counter_if;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  byteenable;
  logic [2:0]  address;
  logic        write;
  logic        read;
  logic        waitrequest;

  modport master (
    output writedata, byteenable, address, write, read,
    input  readdata, waitrequest
  );

  modport slave (
    input  writedata, byteenable, address, write, read,
    output readdata, waitrequest
  );
endinterface

// File: rtl/encoder_input_filter.sv
// One-bit input conditioner for an asynchronous encoder pin: 2-FF synchroniser
// followed by a stable-count filter.
//   csi_MCLK_clk     system clock
//   rsi_MRST_reset_n asynchronous active-low reset
//   pin_i            raw asynchronous pin
//   level_o          filtered level; moves only after FILT_LEN consecutive equal samples
module encoder_input_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic csi_MCLK_clk,
  input  logic rsi_MRST_reset_n,
  input  logic pin_i,
  output logic level_o
);

  logic       sync1_q, sync2_q, level_q;
  logic [3:0] cnt_q;

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      // cnt_q holds how many consecutive samples already disagreed with level_q
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == 4'(FILT_LEN - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/quad_encoder_counter.sv
// Quadrature encoder counter with Avalon-MM slave.
//   csi_MCLK_clk     system clock (only clock)
//   rsi_MRST_reset_n asynchronous active-low reset
//   avs_ctrl         Avalon-MM slave: 8 word registers, readdata registered (1-cycle latency)
//   A, B, Z          asynchronous encoder channels and index
// Filtered A/B are decoded x1/x2/x4 into a CNT_W-bit position, with index capture,
// illegal/wrap detection and a windowed, saturating velocity measurement.
module quad_encoder_counter
  import quad_encoder_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned VEL_W    = 16,
  parameter logic [31:0] ID_VALUE = 32'hEA680013
) (
  input logic                   csi_MCLK_clk,
  input logic                   rsi_MRST_reset_n,
  quad_encoder_counter_if.slave avs_ctrl,
  input logic                   A,
  input logic                   B,
  input logic                   Z
);

  localparam int unsigned DW = VEL_W + 1;  // velocity accumulator width
  localparam logic [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [DW-1:0]    ACC_MAX = {1'b0, {VEL_W{1'b1}}};
  localparam logic [DW-1:0]    ACC_MIN = {1'b1, {VEL_W{1'b0}}};
  localparam logic [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};

  // ---------------- input conditioning ----------------
  logic a_f, b_f, z_f;
  logic a_p_q, b_p_q, z_p_q;

  encoder_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .csi_MCLK_clk    (csi_MCLK_clk),
    .rsi_MRST_reset_n(rsi_MRST_reset_n),
    .pin_i           (A),
    .level_o         (a_f)
  );

  encoder_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .csi_MCLK_clk    (csi_MCLK_clk),
    .rsi_MRST_reset_n(rsi_MRST_reset_n),
    .pin_i           (B),
    .level_o         (b_f)
  );

  encoder_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_z (
    .csi_MCLK_clk    (csi_MCLK_clk),
    .rsi_MRST_reset_n(rsi_MRST_reset_n),
    .pin_i           (Z),
    .level_o         (z_f)
  );

  // ---------------- registers ----------------
  logic [CNT_W-1:0] pos_q, pos_d, idx_q;
  logic [5:0]       ctrl_q;
  logic             dir_q, index_seen_q, illegal_q, wrap_q;
  logic [31:0]      period_q, win_q, win_d;
  logic [DW-1:0]    delta_q, delta_d;
  logic [VEL_W-1:0] vel_q, vel_d;
  logic [31:0]      readdata_q;

  // ---------------- decoder ----------------
  logic [1:0] mode;
  logic       a_chg, b_chg, illegal_ev, idx_ev;
  logic       step_raw, fwd_raw, step_en, step_fwd;

  assign mode       = ctrl_q[CTRL_MODE_LSB +: 2];
  assign a_chg      = a_f ^ a_p_q;
  assign b_chg      = b_f ^ b_p_q;
  assign illegal_ev = a_chg & b_chg;
  assign idx_ev     = z_f & ~z_p_q;

  // Forward order is AB = 00 -> 10 -> 11 -> 01: an A edge is forward when A != B
  // afterwards, a B edge is forward when A == B afterwards.
  always_comb begin
    step_raw = 1'b0;
    fwd_raw  = 1'b0;
    if (!illegal_ev) begin
      case (mode)
        MODE_X1: begin
          step_raw = a_chg & a_f;
          fwd_raw  = ~b_f;
        end
        MODE_X2: begin
          step_raw = a_chg;
          fwd_raw  = a_f ^ b_f;
        end
        MODE_X4, 2'b11: begin
          step_raw = a_chg | b_chg;
          fwd_raw  = a_chg ? (a_f ^ b_f) : ~(a_f ^ b_f);
        end
      endcase
    end
  end

  assign step_en  = step_raw & ctrl_q[CTRL_EN];
  assign step_fwd = fwd_raw ^ ctrl_q[CTRL_INV];

  // ---------------- bus decode ----------------
  logic        wr_pos, wr_status, wr_ctrl, wr_period;
  logic [31:0] rd_cur, wr_merged, status_w;
  logic [3:0]  st_clr;
  logic        unused_read;

  assign unused_read = avs_ctrl.read;
  assign wr_pos      = avs_ctrl.write && (avs_ctrl.address == ADDR_POSITION);
  assign wr_status   = avs_ctrl.write && (avs_ctrl.address == ADDR_STATUS);
  assign wr_ctrl     = avs_ctrl.write && (avs_ctrl.address == ADDR_CTRL);
  assign wr_period   = avs_ctrl.write && (avs_ctrl.address == ADDR_PERIOD);
  // Partial writes keep the unselected bytes of the current register value.
  assign wr_merged   = be_merge(rd_cur, avs_ctrl.writedata, avs_ctrl.byteenable);
  assign st_clr      = {4{wr_status & avs_ctrl.byteenable[0]}} & avs_ctrl.writedata[3:0];

  always_comb begin
    status_w             = '0;
    status_w[ST_DIR]     = dir_q;
    status_w[ST_INDEX]   = index_seen_q;
    status_w[ST_ILLEGAL] = illegal_q;
    status_w[ST_WRAP]    = wrap_q;
  end

  always_comb begin
    case (avs_ctrl.address)
      ADDR_ID:       rd_cur = ID_VALUE;
      ADDR_POSITION: rd_cur = 32'($signed(pos_q));
      ADDR_STATUS:   rd_cur = status_w;
      ADDR_CTRL:     rd_cur = {26'd0, ctrl_q};
      ADDR_INDEX:    rd_cur = 32'($signed(idx_q));
      ADDR_VELOCITY: rd_cur = 32'($signed(vel_q));
      ADDR_PERIOD:   rd_cur = period_q;
      default:       rd_cur = '0;
    endcase
  end

  // ---------------- position ----------------
  logic pos_zclr, pos_step, wrap_ev;

  assign pos_zclr = idx_ev & ctrl_q[CTRL_ZCLR];
  assign pos_step = step_en & ~wr_pos & ~pos_zclr;
  assign wrap_ev  = pos_step & (step_fwd ? (pos_q == POS_MAX) : (pos_q == POS_MIN));

  // Bus write beats zero-on-index, which beats the decoder step.
  always_comb begin
    pos_d = pos_q;
    if (wr_pos) begin
      pos_d = wr_merged[CNT_W-1:0];
    end else if (pos_zclr) begin
      pos_d = '0;
    end else if (step_en) begin
      pos_d = step_fwd ? pos_q + CNT_W'(1) : pos_q - CNT_W'(1);
    end
  end

  // ---------------- velocity ----------------
  logic [DW-1:0] step_inc, acc_sat;
  logic [DW:0]   acc;
  logic [VEL_W-1:0] delta_sat;

  assign step_inc = !step_en ? '0 : (step_fwd ? DW'(1) : '1);
  assign acc      = {delta_q[DW-1], delta_q} + {step_inc[DW-1], step_inc};
  // The accumulator itself saturates so long windows cannot wrap its sign.
  assign acc_sat  = (acc[DW] != acc[DW-1]) ? (acc[DW] ? ACC_MIN : ACC_MAX) : acc[DW-1:0];
  assign delta_sat = (delta_q[DW-1] != delta_q[VEL_W-1]) ?
                     (delta_q[DW-1] ? VEL_MIN : VEL_MAX) : delta_q[VEL_W-1:0];

  always_comb begin
    win_d   = win_q;
    delta_d = delta_q;
    vel_d   = vel_q;
    if (wr_period) begin
      win_d   = '0;
      delta_d = '0;
    end else if (period_q == 32'd0) begin
      win_d   = '0;
      delta_d = '0;
      vel_d   = '0;
    end else if (win_q == period_q - 32'd1) begin
      win_d   = '0;
      vel_d   = delta_sat;
      delta_d = step_inc;
    end else begin
      win_d   = win_q + 32'd1;
      delta_d = acc_sat;
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      a_p_q        <= 1'b0;
      b_p_q        <= 1'b0;
      z_p_q        <= 1'b0;
      pos_q        <= '0;
      idx_q        <= '0;
      ctrl_q       <= CTRL_RESET;
      dir_q        <= 1'b0;
      index_seen_q <= 1'b0;
      illegal_q    <= 1'b0;
      wrap_q       <= 1'b0;
      period_q     <= '0;
      win_q        <= '0;
      delta_q      <= '0;
      vel_q        <= '0;
      readdata_q   <= '0;
    end else begin
      a_p_q      <= a_f;
      b_p_q      <= b_f;
      z_p_q      <= z_f;
      pos_q      <= pos_d;
      win_q      <= win_d;
      delta_q    <= delta_d;
      vel_q      <= vel_d;
      readdata_q <= rd_cur;
      if (idx_ev) idx_q <= pos_q;
      if (step_en) dir_q <= step_fwd;
      // Hardware set wins over a coincident write-1-to-clear.
      index_seen_q <= idx_ev | (index_seen_q & ~st_clr[ST_INDEX]);
      illegal_q    <= illegal_ev | (illegal_q & ~st_clr[ST_ILLEGAL]);
      wrap_q       <= wrap_ev | (wrap_q & ~st_clr[ST_WRAP]);
      if (wr_ctrl) ctrl_q <= wr_merged[5:0] & CTRL_WMASK;
      if (wr_period) period_q <= wr_merged;
    end
  end

  assign avs_ctrl.readdata    = readdata_q;
  assign avs_ctrl.waitrequest = 1'b0;

endmodule
